// File: rtl/gps_spi_bridge_n_pkg.sv
// gps_spi_bridge_n_pkg: state encoding, default parameters and shared widths for the GPS-to-SPI bridge
package gps_spi_bridge_n_pkg;
  localparam int DEF_CH_COUNT          = 4;
  localparam int DEF_SAMPLES_PER_FRAME = 16;
  localparam int DEF_SS_GAP            = 2;
  localparam int DEF_TIMEOUT_CYCLES    = 64;
  localparam int OVR_CNT_W             = 8;
`ifdef BRIDGE_PARITY_EN
  localparam int PAR_BITS = 1;
  typedef enum logic [2:0] {IDLE, SHIFT, PARITY, WAIT, GAP} state_t;
`else
  localparam int PAR_BITS = 0;
  typedef enum logic [2:0] {IDLE, SHIFT, WAIT, GAP} state_t;
`endif
endpackage

// File: rtl/gps_spi_bridge_n_if.sv
// gps_spi_bridge_n_if: GPS sample pins and MCU SPI/status pins of the bridge
interface gps_spi_bridge_n_if #(
  parameter int CH_COUNT = gps_spi_bridge_n_pkg::DEF_CH_COUNT
);
  logic [CH_COUNT-1:0]                       GPS_BITS;
  logic                                      DATAREADY;
  logic                                      MCU_SCK;
  logic                                      MCU_SS;
  logic                                      MCU_MOSI;
  logic                                      OVERRUN;
  logic [gps_spi_bridge_n_pkg::OVR_CNT_W-1:0] OVERRUN_CNT;
  logic                                      FRAME_ACTIVE;
  modport slave (
    input  GPS_BITS, DATAREADY,
    output MCU_SCK, MCU_SS, MCU_MOSI, OVERRUN, OVERRUN_CNT, FRAME_ACTIVE
  );
  modport master (
    output GPS_BITS, DATAREADY,
    input  MCU_SCK, MCU_SS, MCU_MOSI, OVERRUN, OVERRUN_CNT, FRAME_ACTIVE
  );
endinterface

// File: rtl/gps_spi_bridge_n_sample_buf.sv
// gps_spi_bridge_n_sample_buf: one-entry sample hold with sticky overrun flag and saturating drop counter
module gps_spi_bridge_n_sample_buf
  import gps_spi_bridge_n_pkg::*;
#(
  parameter int CH_COUNT = DEF_CH_COUNT
) (
  input  logic                 MCU_CLK_25_000,
  input  logic                 RESET_N,
  input  logic [CH_COUNT-1:0]  gps_bits,
  input  logic                 dataready,
  input  logic                 take,
  output logic                 avail,
  output logic [CH_COUNT-1:0]  avail_bits,
  output logic                 overrun,
  output logic [OVR_CNT_W-1:0] overrun_cnt
);
  logic                hold_valid;
  logic [CH_COUNT-1:0] hold_bits;
  logic                drop, write;
  assign avail      = hold_valid | dataready;
  assign avail_bits = hold_valid ? hold_bits : gps_bits;
  assign drop       = dataready & hold_valid & ~take;
  // a new sample lands in hold when it is not consumed directly and there is (or will be) room
  assign write      = dataready & (hold_valid ? take : ~take);
  always_ff @(posedge MCU_CLK_25_000 or negedge RESET_N) begin
    if (!RESET_N) begin
      hold_valid  <= 1'b0;
      hold_bits   <= '0;
      overrun     <= 1'b0;
      overrun_cnt <= '0;
    end else begin
      if (write) begin
        hold_valid <= 1'b1;
        hold_bits  <= gps_bits;
      end else if (take) begin
        hold_valid <= 1'b0;
      end
      if (drop) begin
        overrun <= 1'b1;
        if (overrun_cnt != '1) overrun_cnt <= overrun_cnt + 1'b1;
      end
    end
  end
endmodule

// File: rtl/gps_spi_bridge_n.sv
// gps_spi_bridge_n: streams CH_COUNT-bit GPS samples LSB-first to an MCU SPI slave in SS-framed bursts
// Optional BRIDGE_PARITY_EN appends an even-parity bit to every sample.
module gps_spi_bridge_n
  import gps_spi_bridge_n_pkg::*;
#(
  parameter int CH_COUNT          = DEF_CH_COUNT,
  parameter int SAMPLES_PER_FRAME = DEF_SAMPLES_PER_FRAME,
  parameter int SS_GAP            = DEF_SS_GAP,
  parameter int TIMEOUT_CYCLES    = DEF_TIMEOUT_CYCLES
) (
  input logic               MCU_CLK_25_000,
  input logic               RESET_N,
  gps_spi_bridge_n_if.slave bus
);
  localparam int SW  = CH_COUNT + PAR_BITS;
  localparam int BW  = $clog2(CH_COUNT + 1);
  localparam int SCW = $clog2(SAMPLES_PER_FRAME + 1);
  localparam int TW  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int GW  = $clog2(SS_GAP + 1);
  state_t              state, state_nx;
  logic [SW-1:0]       shift_reg, shift_nx, load;
  logic                ss, ss_nx, sck_en, sck_nx;
  logic                take, avail, sample_end;
  logic [BW-1:0]       bit_cnt, bit_nx;
  logic [SCW-1:0]      sample_cnt, smp_nx;
  logic [TW-1:0]       timeout_cnt, to_nx;
  logic [GW-1:0]       gap_cnt, gap_nx;
  logic [CH_COUNT-1:0] avail_bits;

  gps_spi_bridge_n_sample_buf #(.CH_COUNT(CH_COUNT)) u_buf (
    .MCU_CLK_25_000 (MCU_CLK_25_000),
    .RESET_N        (RESET_N),
    .gps_bits       (bus.GPS_BITS),
    .dataready      (bus.DATAREADY),
    .take           (take),
    .avail          (avail),
    .avail_bits     (avail_bits),
    .overrun        (bus.OVERRUN),
    .overrun_cnt    (bus.OVERRUN_CNT)
  );

`ifdef BRIDGE_PARITY_EN
  // parity rides in the top bit so it reaches MOSI after the data bits shift out
  assign load = {^avail_bits, avail_bits};
`else
  assign load = avail_bits;
`endif

  assign bus.MCU_SCK      = ~MCU_CLK_25_000 & sck_en;
  assign bus.MCU_SS       = ss;
  assign bus.MCU_MOSI     = shift_reg[0];
  assign bus.FRAME_ACTIVE = (state != IDLE) && (state != GAP);

  always_ff @(posedge MCU_CLK_25_000 or negedge RESET_N) begin
    if (!RESET_N) begin
      state       <= IDLE;
      shift_reg   <= '0;
      ss          <= 1'b1;
      sck_en      <= 1'b0;
      bit_cnt     <= '0;
      sample_cnt  <= '0;
      timeout_cnt <= '0;
      gap_cnt     <= '0;
    end else begin
      state       <= state_nx;
      shift_reg   <= shift_nx;
      ss          <= ss_nx;
      sck_en      <= sck_nx;
      bit_cnt     <= bit_nx;
      sample_cnt  <= smp_nx;
      timeout_cnt <= to_nx;
      gap_cnt     <= gap_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    shift_nx   = shift_reg;
    ss_nx      = ss;
    sck_nx     = sck_en;
    bit_nx     = bit_cnt;
    smp_nx     = sample_cnt;
    to_nx      = timeout_cnt;
    gap_nx     = gap_cnt;
    take       = 1'b0;
    sample_end = 1'b0;
    case (state)
      IDLE: begin
        ss_nx  = 1'b1;
        sck_nx = 1'b0;
        if (avail) begin
          take     = 1'b1;
          shift_nx = load;
          ss_nx    = 1'b0;
          sck_nx   = 1'b1;
          bit_nx   = '0;
          smp_nx   = '0;
          state_nx = SHIFT;
        end
      end
      SHIFT: begin
        shift_nx = shift_reg >> 1;
        bit_nx   = bit_cnt + 1'b1;
`ifdef BRIDGE_PARITY_EN
        if (bit_cnt == BW'(CH_COUNT - 1)) state_nx = PARITY;
`else
        sample_end = bit_cnt == BW'(CH_COUNT - 1);
`endif
      end
`ifdef BRIDGE_PARITY_EN
      PARITY: sample_end = 1'b1;
`endif
      WAIT: begin
        to_nx = timeout_cnt + 1'b1;
        if (avail) begin
          take     = 1'b1;
          shift_nx = load;
          sck_nx   = 1'b1;
          to_nx    = '0;
          bit_nx   = '0;
          smp_nx   = sample_cnt + 1'b1;
          state_nx = SHIFT;
        end else if (timeout_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
          ss_nx    = 1'b1;
          gap_nx   = '0;
          state_nx = GAP;
        end
      end
      GAP: begin
        gap_nx   = gap_cnt + 1'b1;
        state_nx = (gap_cnt == GW'(SS_GAP - 1)) ? IDLE : GAP;
      end
      default: begin
        ss_nx    = 1'b1;
        sck_nx   = 1'b0;
        state_nx = IDLE;
      end
    endcase
    // end of a sample: close a full frame, chain the next sample without an SCK gap, or park in WAIT
    if (sample_end) begin
      if (sample_cnt == SCW'(SAMPLES_PER_FRAME - 1)) begin
        ss_nx    = 1'b1;
        sck_nx   = 1'b0;
        gap_nx   = '0;
        state_nx = GAP;
      end else if (avail) begin
        take     = 1'b1;
        shift_nx = load;
        bit_nx   = '0;
        smp_nx   = sample_cnt + 1'b1;
        state_nx = SHIFT;
      end else begin
        sck_nx   = 1'b0;
        to_nx    = '0;
        state_nx = WAIT;
      end
    end
  end
endmodule

// File: tb/tb_gps_spi_bridge_n.sv
// tb_gps_spi_bridge_n: randomized scoreboard bench for gps_spi_bridge_n against a transaction-level model
module tb_gps_spi_bridge_n;
  import gps_spi_bridge_n_pkg::*;
  localparam int CH  = 4;
  localparam int SPF = 16;
  localparam int GAP = 2;
  localparam int TO  = 64;
  localparam int NB  = CH + PAR_BITS;

  logic mcu_clk = 1'b0;
  logic rst_n   = 1'b1;
  int   checks  = 0;
  int   errors  = 0;

  gps_spi_bridge_n_if #(.CH_COUNT(CH)) bus ();
  gps_spi_bridge_n #(.CH_COUNT(CH), .SAMPLES_PER_FRAME(SPF), .SS_GAP(GAP), .TIMEOUT_CYCLES(TO)) dut (
    .MCU_CLK_25_000 (mcu_clk),
    .RESET_N        (rst_n),
    .bus            (bus)
  );

  always #20 mcu_clk = ~mcu_clk;

  logic [NB-1:0] exp_q[$];
  logic [CH-1:0] m_hold[$];
  bit            m_frame;
  int            m_bits_left, m_idle, m_gap_left, m_in_frame, m_ovr, m_frames;
  int            dut_frames, nrx;
  logic [NB-1:0] rx;
  bit            prev_ss = 1'b1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, got, want, $time);
    end
  endtask

  function automatic logic [NB-1:0] frame_word(input logic [CH-1:0] w);
`ifdef BRIDGE_PARITY_EN
    return {^w, w};
`else
    return w;
`endif
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_hold.delete();
    m_frame     = 1'b0;
    m_bits_left = 0;
    m_idle      = 0;
    m_gap_left  = 0;
    m_in_frame  = 0;
    m_ovr       = 0;
    nrx         = 0;
  endtask

  task automatic close_frame();
    m_frame    = 1'b0;
    m_gap_left = GAP;
    m_frames++;
  endtask

  // one clock of the bridge, described as sample-slot bookkeeping rather than bit-level state
  task automatic model_step();
    logic          dr;
    logic [CH-1:0] b;
    bit            avail, took;
    dr    = bus.DATAREADY;
    b     = bus.GPS_BITS;
    avail = (m_hold.size() > 0) || dr;
    took  = 1'b0;
    if (m_gap_left > 0) m_gap_left--;
    else if (!m_frame) begin
      if (avail) begin
        took = 1'b1; m_frame = 1'b1; m_in_frame = 1; m_bits_left = NB;
      end
    end else if (m_bits_left > 0) begin
      m_bits_left--;
      if (m_bits_left == 0) begin
        if (m_in_frame == SPF) close_frame();
        else if (avail) begin took = 1'b1; m_in_frame++; m_bits_left = NB; end
        else m_idle = 0;
      end
    end else if (avail) begin
      took = 1'b1; m_in_frame++; m_bits_left = NB;
    end else if (m_idle == TO - 1) close_frame();
    else m_idle++;
    if (took) begin
      if (m_hold.size() > 0) begin
        exp_q.push_back(frame_word(m_hold.pop_front()));
        if (dr) m_hold.push_back(b);
      end else exp_q.push_back(frame_word(b));
    end else if (dr) begin
      if (m_hold.size() > 0) m_ovr = (m_ovr < 255) ? m_ovr + 1 : 255;
      else m_hold.push_back(b);
    end
  endtask

  initial forever begin
    @(posedge mcu_clk or negedge rst_n);
    if (!rst_n) model_reset();
    else model_step();
  end

  initial forever begin
    @(posedge bus.MCU_SCK);
    check("ss_low_at_sck", bus.MCU_SS, 0);
    rx = {bus.MCU_MOSI, rx[NB-1:1]};
    nrx++;
    if (nrx == NB) begin
      nrx = 0;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sample_unexpected got %0h expected none at %0t", rx, $time);
      end else check("sample", rx, exp_q.pop_front());
    end
  end

  initial forever begin
    @(negedge mcu_clk);
    if (rst_n) begin
      check("ss", bus.MCU_SS, !m_frame);
      check("frame_active", bus.FRAME_ACTIVE, m_frame);
      check("overrun", bus.OVERRUN, m_ovr > 0);
      check("overrun_cnt", bus.OVERRUN_CNT, m_ovr);
      if (!prev_ss && bus.MCU_SS) dut_frames++;
      prev_ss = bus.MCU_SS;
    end else prev_ss = 1'b1;
  end

  task automatic drive(input bit dr, input logic [CH-1:0] b);
    @(negedge mcu_clk);
    bus.DATAREADY = dr;
    bus.GPS_BITS  = b;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, CH'($urandom));
  endtask

  task automatic random_traffic(input int bursts);
    int len, pct;
    for (int i = 0; i < bursts; i++) begin
      len = $urandom_range(60, 1);
      pct = $urandom_range(4) * 25;
      if ($urandom_range(5) == 0) idle($urandom_range(90, 60));
      for (int j = 0; j < len; j++) drive($urandom_range(99) < pct, CH'($urandom));
    end
  endtask

  initial begin
    bus.DATAREADY = 1'b0;
    bus.GPS_BITS  = '0;
    #5 rst_n = 1'b0;
    #5;
    check("rst_ss", bus.MCU_SS, 1);
    check("rst_sck", bus.MCU_SCK, 0);
    check("rst_mosi", bus.MCU_MOSI, 0);
    check("rst_overrun", bus.OVERRUN, 0);
    check("rst_overrun_cnt", bus.OVERRUN_CNT, 0);
    check("rst_frame_active", bus.FRAME_ACTIVE, 0);
    repeat (3) @(negedge mcu_clk);
    rst_n = 1'b1;
    drive(1'b1, 4'b1010);
    idle(TO + 12);
    for (int i = 0; i < SPF; i++) begin
      drive(1'b1, CH'($urandom));
      idle(NB - 1);
    end
    idle(10);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, CH'($urandom));
      idle(NB - 1);
    end
    idle(TO + 12);
    for (int i = 0; i < 8; i++) drive(1'b1, CH'($urandom));
    idle(150);
    check("overrun_cnt_burst8", bus.OVERRUN_CNT, 5);
    random_traffic(40);
    for (int i = 0; i < 400; i++) drive(1'b1, CH'($urandom));
    check("overrun_cnt_saturated", bus.OVERRUN_CNT, 8'hFF);
    idle(100);
    drive(1'b1, 4'b0100);
    idle(3);
    check("mosi_bit2_before_reset", bus.MCU_MOSI, 1);
    #5 rst_n = 1'b0;
    #1;
    check("midrst_ss", bus.MCU_SS, 1);
    check("midrst_sck", bus.MCU_SCK, 0);
    check("midrst_mosi", bus.MCU_MOSI, 0);
    check("midrst_overrun_cnt", bus.OVERRUN_CNT, 0);
    @(negedge mcu_clk);
    rst_n = 1'b1;
    drive(1'b1, 4'b1010);
    random_traffic(20);
    idle(200);
    check("scoreboard_drained", exp_q.size(), 0);
    check("no_partial_sample", nrx, 0);
    check("frame_count", dut_frames, m_frames);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
